// File: rtl/lsu_mmio_param_if.sv
// Request/response bus between the pipeline and lsu_mmio_param.
// The master drives the request fields and the slave drives the response fields.
interface lsu_mmio_param_if;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_addr;
  logic [2:0]  i_funct3;
  logic [31:0] i_st_data;
  logic        o_ready;
  logic        o_rvalid;
  logic [31:0] o_ld_data;
  logic        o_err;

  modport master (output i_req, i_we, i_addr, i_funct3, i_st_data,
                  input  o_ready, o_rvalid, o_ld_data, o_err);
  modport slave  (input  i_req, i_we, i_addr, i_funct3, i_st_data,
                  output o_ready, o_rvalid, o_ld_data, o_err);
endinterface

// File: rtl/lsu_mmio_param.sv
// Load-store unit: DMEM plus LEDR/LEDG/HEX/LCD/SW memory-mapped IO with a req/ready handshake.
// Macro LSU_MISALIGN_SPLIT_EN enables word-crossing accesses, split over a second beat.
module lsu_mmio_param #(
  parameter int DMEM_BYTES = 2048,
  parameter int NUM_HEX    = 8,
  parameter int LEDR_W     = 17,
  parameter int LEDG_W     = 8,
  parameter int SW_W       = 17
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  lsu_mmio_param_if.slave      bus,
  input  logic [SW_W-1:0]      i_io_sw,
  output logic [LEDR_W-1:0]    o_ledr,
  output logic [LEDG_W-1:0]    o_ledg,
  output logic [NUM_HEX*7-1:0] o_hex,
  output logic [31:0]          o_lcd
);
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  localparam int DMEM_WORDS = DMEM_BYTES / 4;
  localparam int IDX_W      = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam int HEX_W      = NUM_HEX * 4;
  localparam logic [31:0] A_LEDR = 32'h1000_0000;
  localparam logic [31:0] A_LEDG = 32'h1000_1000;
  localparam logic [31:0] A_HEX  = 32'h1000_2000;
  localparam logic [31:0] A_LCD  = 32'h1000_4000;
  localparam logic [31:0] A_SW   = 32'h1001_0000;

  typedef enum logic [1:0] {S_IDLE, S_BEAT2, S_RESP} state_e;
  typedef enum logic [2:0] {R_NONE, R_DMEM, R_LEDR, R_LEDG, R_HEX, R_LCD, R_SW} region_e;

  state_e              state_q;
  logic                ready_q, rvalid_q, err_q, we_q;
  logic [31:0]         ld_data_q, addr_q, st_q, lo_q, lcd_q;
  logic [2:0]          f3_q;
  logic [LEDR_W-1:0]   ledr_q;
  logic [LEDG_W-1:0]   ledg_q;
  logic [HEX_W-1:0]    hex_q;
  logic [SW_W-1:0]     sw_sync1_q, sw_sync2_q;
  logic [31:0]         mem_q [DMEM_WORDS];

  logic        idle_s, acc_we_s, cross_s, misal_s, f3_bad_s, err_s, wr_en_s;
  logic [31:0] acc_addr_s, acc_st_s, wr_data_s, rd_word_s, io_merged_s, ld_sh_s, ld_ext_s;
  logic [31:0] rd_lo_s, rd_hi_s;
  logic [2:0]  acc_f3_s;
  logic [1:0]  off_s;
  logic [29:0] word_a_s, word_b_s, wr_word_s;
  logic [7:0]  mask_base_s, mask_s;
  logic [63:0] st64_s;
  logic [3:0]  wr_be_s;
  region_e     reg_a_s, reg_b_s, wr_region_s;

  function automatic region_e decode_region(input logic [29:0] w);
    region_e r;
    if (w < 30'(DMEM_WORDS)) begin
      r = R_DMEM;
    end else begin
      case (w)
        A_LEDR[31:2]: r = R_LEDR;
        A_LEDG[31:2]: r = R_LEDG;
        A_HEX[31:2]:  r = R_HEX;
        A_LCD[31:2]:  r = R_LCD;
        A_SW[31:2]:   r = R_SW;
        default:      r = R_NONE;
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] m;
    m = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) m[8*b +: 8] = new_w[8*b +: 8];
    end
    return m;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Access decode: IDLE looks at the live request, BEAT2 at the latched one.
  always_comb begin
    idle_s     = (state_q == S_IDLE);
    acc_addr_s = idle_s ? bus.i_addr    : addr_q;
    acc_f3_s   = idle_s ? bus.i_funct3  : f3_q;
    acc_st_s   = idle_s ? bus.i_st_data : st_q;
    acc_we_s   = idle_s ? bus.i_we      : we_q;
    off_s      = acc_addr_s[1:0];
    word_a_s   = acc_addr_s[31:2];
    word_b_s   = word_a_s + 30'd1;
    case (acc_f3_s[1:0])
      2'b00:   mask_base_s = 8'h01;
      2'b01:   mask_base_s = 8'h03;
      2'b10:   mask_base_s = 8'h0F;
      default: mask_base_s = 8'h00;
    endcase
    mask_s   = mask_base_s << off_s;
    cross_s  = |mask_s[7:4];
    misal_s  = ((acc_f3_s[1:0] == 2'b01) && off_s[0]) || ((acc_f3_s[1:0] == 2'b10) && (off_s != 2'b00));
    f3_bad_s = (acc_f3_s == 3'b011) || (acc_f3_s[2:1] == 2'b11);
    reg_a_s  = decode_region(word_a_s);
    reg_b_s  = decode_region(word_b_s);
    // Both words are vetted up front so a failing second beat never leaves a half-written store.
    err_s    = f3_bad_s || (reg_a_s == R_NONE) || (cross_s && (reg_b_s == R_NONE)) ||
               (acc_we_s && ((reg_a_s == R_SW) || (cross_s && (reg_b_s == R_SW)))) ||
               (!SPLIT && misal_s);
    st64_s      = {32'h0000_0000, acc_st_s} << {off_s, 3'b000};
    wr_word_s   = idle_s ? word_a_s : word_b_s;
    wr_region_s = idle_s ? reg_a_s : reg_b_s;
    wr_be_s     = idle_s ? mask_s[3:0] : mask_s[7:4];
    wr_data_s   = idle_s ? st64_s[31:0] : st64_s[63:32];
    wr_en_s     = i_rstn && acc_we_s && !err_s &&
                  ((idle_s && bus.i_req) || (state_q == S_BEAT2));
    case (wr_region_s)
      R_DMEM:  rd_word_s = mem_q[wr_word_s[IDX_W-1:0]];
      R_LEDR:  rd_word_s = 32'(ledr_q);
      R_LEDG:  rd_word_s = 32'(ledg_q);
      R_HEX:   rd_word_s = 32'(hex_q);
      R_LCD:   rd_word_s = lcd_q;
      R_SW:    rd_word_s = 32'(sw_sync2_q);
      default: rd_word_s = 32'h0000_0000;
    endcase
    io_merged_s = merge_be(rd_word_s, wr_data_s, wr_be_s);
    rd_lo_s  = idle_s ? rd_word_s : lo_q;
    rd_hi_s  = idle_s ? 32'h0000_0000 : rd_word_s;
    ld_sh_s  = 32'({rd_hi_s, rd_lo_s} >> {off_s, 3'b000});
    case (acc_f3_s)
      3'b000:  ld_ext_s = {{24{ld_sh_s[7]}}, ld_sh_s[7:0]};
      3'b001:  ld_ext_s = {{16{ld_sh_s[15]}}, ld_sh_s[15:0]};
      3'b010:  ld_ext_s = ld_sh_s;
      3'b100:  ld_ext_s = {24'h00_0000, ld_sh_s[7:0]};
      3'b101:  ld_ext_s = {16'h0000, ld_sh_s[15:0]};
      default: ld_ext_s = 32'h0000_0000;
    endcase
  end

  // DMEM byte-enabled write port; contents intentionally survive reset.
  always_ff @(posedge i_clk) begin
    if (wr_en_s && (wr_region_s == R_DMEM)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_s[b]) mem_q[wr_word_s[IDX_W-1:0]][8*b +: 8] <= wr_data_s[8*b +: 8];
      end
    end
  end

  // Control FSM, response registers, IO registers and switch synchroniser.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      ld_data_q  <= 32'h0000_0000;
      addr_q     <= 32'h0000_0000;
      st_q       <= 32'h0000_0000;
      f3_q       <= 3'b000;
      we_q       <= 1'b0;
      lo_q       <= 32'h0000_0000;
      ledr_q     <= '0;
      ledg_q     <= '0;
      hex_q      <= '0;
      lcd_q      <= 32'h0000_0000;
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      sw_sync1_q <= i_io_sw;
      sw_sync2_q <= sw_sync1_q;
      rvalid_q   <= 1'b0;
      if (wr_en_s) begin
        case (wr_region_s)
          R_LEDR:  ledr_q <= io_merged_s[LEDR_W-1:0];
          R_LEDG:  ledg_q <= io_merged_s[LEDG_W-1:0];
          R_HEX:   hex_q  <= io_merged_s[HEX_W-1:0];
          R_LCD:   lcd_q  <= io_merged_s;
          default: ;
        endcase
      end
      case (state_q)
        S_IDLE: begin
          if (bus.i_req) begin
            addr_q  <= bus.i_addr;
            st_q    <= bus.i_st_data;
            f3_q    <= bus.i_funct3;
            we_q    <= bus.i_we;
            lo_q    <= rd_word_s;
            ready_q <= 1'b0;
            if (SPLIT && cross_s && !err_s) begin
              state_q <= S_BEAT2;
            end else begin
              state_q   <= S_RESP;
              rvalid_q  <= 1'b1;
              err_q     <= err_s;
              ld_data_q <= (err_s || bus.i_we) ? 32'h0000_0000 : ld_ext_s;
            end
          end
        end
        S_BEAT2: begin
          state_q   <= S_RESP;
          rvalid_q  <= 1'b1;
          err_q     <= 1'b0;
          ld_data_q <= we_q ? 32'h0000_0000 : ld_ext_s;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Seven-segment decode of the HEX nibble register.
  always_comb begin
    o_hex = '0;
    for (int k = 0; k < NUM_HEX; k++) o_hex[7*k +: 7] = seg7(hex_q[4*k +: 4]);
  end

  assign bus.o_ready   = ready_q;
  assign bus.o_rvalid  = rvalid_q;
  assign bus.o_ld_data = ld_data_q;
  assign bus.o_err     = err_q;
  assign o_ledr        = ledr_q;
  assign o_ledg        = ledg_q;
  assign o_lcd         = lcd_q;
endmodule

// File: tb/tb_lsu_mmio_param.sv
// Scoreboard bench for lsu_mmio_param: stimulus queues expected responses, a monitor checks them.
module tb_lsu_mmio_param;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [16:0] io_sw;
  logic [16:0] ledr;
  logic [7:0]  ledg;
  logic [55:0] hex;
  logic [31:0] lcd;

  lsu_mmio_param_if bus();

  lsu_mmio_param #(.DMEM_BYTES(2048), .NUM_HEX(8), .LEDR_W(17), .LEDG_W(8), .SW_W(17)) dut (
    .i_clk(clk), .i_rstn(rstn), .bus(bus), .i_io_sw(io_sw),
    .o_ledr(ledr), .o_ledg(ledg), .o_hex(hex), .o_lcd(lcd));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && bus.o_rvalid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid=1 expected no response (data %h)", bus.o_ld_data);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_data"}, 64'(bus.o_ld_data), 64'(e.data));
        check({e.name, "_err"}, 64'(bus.o_err), 64'(e.err));
        if (e.lat > 0) check({e.name, "_lat"}, 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL response_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] st, input logic [31:0] exp_d, input logic exp_e,
                       input int lat, input string name);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_we = we; bus.i_addr = addr; bus.i_funct3 = f3; bus.i_st_data = st;
    while (!bus.o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: got ready=0 expected 1", name);
      bus.i_req = 1'b0;
    end else begin
      e.data = exp_d; e.err = exp_e; e.lat = lat; e.acc = cyc; e.name = name;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      bus.i_req = 1'b0;
      drain();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = 32'h0; bus.i_funct3 = 3'b000; bus.i_st_data = 32'h0;
    io_sw = 17'h0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(bus.o_ready), 64'h1);
    check("rst_rvalid", 64'(bus.o_rvalid), 64'h0);
    check("rst_lddata", 64'(bus.o_ld_data), 64'h0);
    check("rst_err", 64'(bus.o_err), 64'h0);
    check("rst_ledr", 64'(ledr), 64'h0);
    check("rst_ledg", 64'(ledg), 64'h0);
    check("rst_hex", 64'(hex), 64'({8{7'h40}}));
    check("rst_lcd", 64'(lcd), 64'h0);

    // Word store/load and byte/half extension
    issue(1'b1, 32'h10, LW, 32'h1234_5678, 32'h0, 1'b0, 1, "sw10");
    issue(1'b0, 32'h10, LW, 32'h0, 32'h1234_5678, 1'b0, 1, "lw10");
    issue(1'b1, 32'h13, LB, 32'h0000_00FF, 32'h0, 1'b0, 1, "sb13");
    issue(1'b0, 32'h13, LB, 32'h0, 32'hFFFF_FFFF, 1'b0, 1, "lb13");
    issue(1'b0, 32'h13, LBU, 32'h0, 32'h0000_00FF, 1'b0, 1, "lbu13");
    issue(1'b0, 32'h10, LW, 32'h0, 32'hFF34_5678, 1'b0, 1, "lw10b");
    issue(1'b0, 32'h12, LH, 32'h0, 32'hFFFF_FF34, 1'b0, 1, "lh12");
    issue(1'b0, 32'h12, LHU, 32'h0, 32'h0000_FF34, 1'b0, 1, "lhu12");

    // Misaligned / word-crossing accesses
    issue(1'b1, 32'h0C, LW, 32'h0, 32'h0, 1'b0, 1, "sw0c");
`ifdef LSU_MISALIGN_SPLIT_EN
    issue(1'b1, 32'h0E, LW, 32'hAABB_CCDD, 32'h0, 1'b0, 2, "sw0e");
    issue(1'b0, 32'h0C, LW, 32'h0, 32'hCCDD_0000, 1'b0, 1, "lw0c");
    issue(1'b0, 32'h10, LW, 32'h0, 32'hFF34_AABB, 1'b0, 1, "lw10c");
    issue(1'b0, 32'h0E, LW, 32'h0, 32'hAABB_CCDD, 1'b0, 2, "lw0e");
    issue(1'b0, 32'h0F, LH, 32'h0, 32'hFFFF_BBCC, 1'b0, 2, "lh0f");
    issue(1'b0, 32'h0D, LH, 32'h0, 32'hFFFF_DD00, 1'b0, 1, "lh0d");
`else
    issue(1'b1, 32'h0E, LW, 32'hAABB_CCDD, 32'h0, 1'b1, 1, "sw0e");
    issue(1'b0, 32'h0C, LW, 32'h0, 32'h0, 1'b0, 1, "lw0c");
    issue(1'b0, 32'h10, LW, 32'h0, 32'hFF34_5678, 1'b0, 1, "lw10c");
    issue(1'b0, 32'h0E, LW, 32'h0, 32'h0, 1'b1, 1, "lw0e");
    issue(1'b0, 32'h0F, LH, 32'h0, 32'h0, 1'b1, 1, "lh0f");
    issue(1'b0, 32'h0D, LH, 32'h0, 32'h0, 1'b1, 1, "lh0d");
`endif

    // DMEM top boundary: crossing into unmapped space never writes
    issue(1'b1, 32'h7FC, LW, 32'h0, 32'h0, 1'b0, 1, "sw7fc");
    issue(1'b1, 32'h7FE, LW, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, "sw7fe");
    issue(1'b0, 32'h7FC, LW, 32'h0, 32'h0, 1'b0, 1, "lw7fc");
    issue(1'b0, 32'h7FF, LH, 32'h0, 32'h0, 1'b1, 1, "lh7ff");

    // Memory-mapped IO
    issue(1'b1, 32'h1000_2000, LW, 32'h0000_ABCD, 32'h0, 1'b0, 1, "swhex");
    check("hex_abcd", 64'(hex), 64'({7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h03, 7'h46, 7'h21}));
    issue(1'b0, 32'h1000_2000, LW, 32'h0, 32'h0000_ABCD, 1'b0, 1, "lwhex");
    issue(1'b1, 32'h1000_0001, LB, 32'h0000_005A, 32'h0, 1'b0, 1, "sbledr");
    check("ledr_byte1", 64'(ledr), 64'h5A00);
    issue(1'b0, 32'h1000_0000, LW, 32'h0, 32'h0000_5A00, 1'b0, 1, "lwledr");
    issue(1'b1, 32'h1000_1000, LW, 32'hFFFF_FFFF, 32'h0, 1'b0, 1, "swledg");
    check("ledg_trunc", 64'(ledg), 64'hFF);
    issue(1'b0, 32'h1000_1000, LW, 32'h0, 32'h0000_00FF, 1'b0, 1, "lwledg");
    issue(1'b1, 32'h1000_4000, LW, 32'hDEAD_BEEF, 32'h0, 1'b0, 1, "swlcd");
    check("lcd_word", 64'(lcd), 64'hDEAD_BEEF);
    issue(1'b0, 32'h1000_4002, LHU, 32'h0, 32'h0000_DEAD, 1'b0, 1, "lhulcd");

    io_sw = 17'h1_5555;
    repeat (2) @(posedge clk);
    issue(1'b0, 32'h1001_0000, LW, 32'h0, 32'h0001_5555, 1'b0, 1, "lwsw");
    issue(1'b1, 32'h1001_0000, LW, 32'h1234_5678, 32'h0, 1'b1, 1, "swsw");

    // Errors: unmapped and invalid funct3
    issue(1'b0, 32'h2000_0000, LW, 32'h0, 32'h0, 1'b1, 1, "lwunmap");
    issue(1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1, 1, "badf3ld");
    issue(1'b1, 32'h1000_0000, 3'b111, 32'h0000_0001, 32'h0, 1'b1, 1, "badf3st");
    check("ledr_unchanged", 64'(ledr), 64'h5A00);

    // Reset abort
`ifdef LSU_MISALIGN_SPLIT_EN
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_addr = 32'h0E; bus.i_funct3 = LW; bus.i_st_data = 32'h1122_3344;
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("abort_rvalid", 64'(bus.o_rvalid), 64'h0);
    check("abort_ready", 64'(bus.o_ready), 64'h1);
    check("abort_ledr", 64'(ledr), 64'h0);
    issue(1'b0, 32'h0C, LW, 32'h0, 32'h3344_0000, 1'b0, 1, "lw0c_abort");
    issue(1'b0, 32'h10, LW, 32'h0, 32'hFF34_AABB, 1'b0, 1, "lw10_abort");
`else
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("abort_ready", 64'(bus.o_ready), 64'h1);
    check("abort_ledr", 64'(ledr), 64'h0);
    check("abort_hex", 64'(hex), 64'({8{7'h40}}));
    issue(1'b0, 32'h10, LW, 32'h0, 32'hFF34_5678, 1'b0, 1, "lw10_keep");
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
